// File: rtl/brique_mur.sv
// brique_mur: brick-wall pixel renderer with a probe/destroy handshake for the ball logic.
module brique_mur #(
  parameter int NCOLS             = 3,
  parameter int NROWS             = 3,
  parameter int LARGEUR_BRIQUE    = 210,
  parameter int HAUTEUR_BRIQUE    = 80,
  parameter int INTERVALLE_BRIQUE = 1,
  parameter int H_ORIGINE         = 112,
  parameter int V_BAS             = 492,
  parameter int COULEUR_BRIQUE    = 18,
  parameter int PAS_COULEUR       = 0,
  parameter int BLANC             = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  output logic [4:0]  Couleur,
  input  logic        probe_valid,
  input  logic [10:0] probe_h,
  input  logic [10:0] probe_v,
  output logic        probe_ready,
  output logic        probe_done,
  output logic        probe_hit,
  input  logic        rebuild,
  output logic [6:0]  restant,
  output logic        mur_vide
);
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
  localparam int N = NCOLS * NROWS;
  state_t      state_q, state_d;
  logic [63:0] alive_q, alive_d;
  logic [6:0]  restant_q, restant_d;
  logic        mur_vide_q, mur_vide_d;
  logic [4:0]  couleur_q, couleur_d;
  logic [10:0] ph_q, ph_d, pv_q, pv_d;
  logic        hit_q, hit_d;
  logic [5:0]  idx_q, idx_d;
  logic [9:0]  pix_m, prb_m;
  // Result packs {found, row, linear index}; regions are disjoint so the last match is the only one.
  function automatic logic [9:0] locate(input logic [10:0] h, input logic [10:0] v);
    int hh, vv;
    logic [9:0] m;
    hh = int'(h);
    vv = int'(v);
    m = '0;
    for (int r = 0; r < NROWS; r++)
      for (int c = 0; c < NCOLS; c++)
        if (hh >= H_ORIGINE + LARGEUR_BRIQUE * c + INTERVALLE_BRIQUE &&
            hh <  H_ORIGINE + LARGEUR_BRIQUE * (c + 1) - INTERVALLE_BRIQUE &&
            vv >= V_BAS - (HAUTEUR_BRIQUE * (r + 1) - INTERVALLE_BRIQUE) &&
            vv <  V_BAS - (HAUTEUR_BRIQUE * r + INTERVALLE_BRIQUE))
          m = {1'b1, 3'(r), 6'(r * NCOLS + c)};
    return m;
  endfunction
  always_comb begin
    pix_m      = locate(hpos, vpos);
    prb_m      = locate(ph_q, pv_q);
    couleur_d  = (pix_m[9] && alive_q[pix_m[5:0]]) ?
                 5'(COULEUR_BRIQUE + int'(pix_m[8:6]) * PAS_COULEUR) : 5'(BLANC);
    state_d    = state_q;
    alive_d    = alive_q;
    restant_d  = restant_q;
    ph_d       = ph_q;
    pv_d       = pv_q;
    hit_d      = hit_q;
    idx_d      = idx_q;
    if (rebuild) begin
      state_d   = IDLE;
      alive_d   = '1;
      restant_d = 7'(N);
    end else if (state_q == IDLE) begin
      if (probe_valid) begin
        ph_d    = probe_h;
        pv_d    = probe_v;
        state_d = LOOKUP;
      end
    end else if (state_q == LOOKUP) begin
      hit_d   = prb_m[9] && alive_q[prb_m[5:0]];
      idx_d   = prb_m[5:0];
      state_d = RESP;
    end else begin
      state_d = IDLE;
      if (hit_q) begin
        alive_d[idx_q] = 1'b0;
        restant_d      = restant_q - 7'd1;
      end
    end
    mur_vide_d = restant_d == 7'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alive_q    <= '1;
      restant_q  <= 7'(N);
      mur_vide_q <= 1'b0;
      couleur_q  <= 5'(BLANC);
      ph_q       <= '0;
      pv_q       <= '0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      alive_q    <= alive_d;
      restant_q  <= restant_d;
      mur_vide_q <= mur_vide_d;
      couleur_q  <= couleur_d;
      ph_q       <= ph_d;
      pv_q       <= pv_d;
      hit_q      <= hit_d;
      idx_q      <= idx_d;
    end
  end
  assign Couleur     = couleur_q;
  assign probe_ready = (state_q == IDLE) && !rebuild;
  assign probe_done  = state_q == RESP;
  assign probe_hit   = (state_q == RESP) && hit_q;
  assign restant     = restant_q;
  assign mur_vide    = mur_vide_q;
endmodule
